res_station: RTL and testbench

Reservation station that sits directly upstream of the `exec` unit in the Tomasulo core. It buffers issued instructions whose operands may still be pending and snoops the common data bus (CDB) to capture results by ROB tag. It dispatches one fully-ready instruction per cycle to `exec`, using the same `rs1_data`/`rs2_data`/`func`/`rob_ind`/`rd`/`exec_b` signal set that `exec` consumes.

---
 rtl/tomasulo_pkg.sv | 52 +++++
 rtl/res_station_if.sv | 52 +++++
 rtl/rs_entry.sv | 76 +++++++
 rtl/res_station.sv | 107 ++++++++++
 tb/tb_res_station.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo widths, func codes and bundles.
// Used by the reservation station, exec and the ROB.
package tomasulo_pkg;

  localparam int DATA_W = 8;
  localparam int FUNC_W = 4;
  localparam int REG_W  = 4;
  localparam int ROB_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [FUNC_W-1:0] func_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [ROB_W-1:0]  rob_t;

  typedef enum logic [FUNC_W-1:0] {
    F_ADD = 4'b0000,
    F_SUB = 4'b0001,
    F_MUL = 4'b0010,
    F_DIV = 4'b0011,
    F_LD  = 4'b0100,
    F_ST  = 4'b0101
  } func_e;

  typedef struct packed {
    func_t func;
    reg_t  rd;
    rob_t  rob;
    data_t vj;
    data_t vk;
    logic  rdy_j;
    logic  rdy_k;
    rob_t  qj;
    rob_t  qk;
  } issue_t;

  typedef struct packed {
    func_t func;
    reg_t  rd;
    rob_t  rob;
    data_t vj;
    data_t vk;
  } op_t;

  function automatic logic tag_hit(
    input logic v,
    input rob_t a,
    input rob_t b
  );
    return v && (a == b);
  endfunction

endpackage

// File: rtl/res_station_if.sv
// Issue, CDB and dispatch bundle of the station.
// master = issue/CDB/exec side, slave = station.
interface res_station_if;
  import tomasulo_pkg::*;

  logic  issue_valid;
  logic  issue_ready;
  func_t issue_func;
  reg_t  issue_rd;
  rob_t  issue_rob;
  data_t issue_vj;
  data_t issue_vk;
  logic  issue_rdy_j;
  logic  issue_rdy_k;
  rob_t  issue_qj;
  rob_t  issue_qk;

  logic  cdb_valid;
  rob_t  cdb_tag;
  data_t cdb_data;

  logic  exec_ready;
  logic  exec_b;
  func_t func;
  reg_t  rd;
  rob_t  rob_ind;
  data_t rs1_data;
  data_t rs2_data;

  modport master (
    output issue_valid, issue_func, issue_rd,
    output issue_rob, issue_vj, issue_vk,
    output issue_rdy_j, issue_rdy_k,
    output issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data,
    output exec_ready,
    input  issue_ready, exec_b, func, rd,
    input  rob_ind, rs1_data, rs2_data
  );

  modport slave (
    input  issue_valid, issue_func, issue_rd,
    input  issue_rob, issue_vj, issue_vk,
    input  issue_rdy_j, issue_rdy_k,
    input  issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data,
    input  exec_ready,
    output issue_ready, exec_b, func, rd,
    output rob_ind, rs1_data, rs2_data
  );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: storage, issue
// write with CDB bypass, and operand wakeup.
module rs_entry
  import tomasulo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  issue_t issue,
  input  logic   cdb_valid,
  input  rob_t   cdb_tag,
  input  data_t  cdb_data,
  input  logic   deq,
  output logic   busy,
  output logic   ready,
  output op_t    op
);

  logic rdy_j;
  logic rdy_k;
  rob_t qj;
  rob_t qk;

  logic byp_j;
  logic byp_k;
  logic hit_j;
  logic hit_k;

  assign byp_j = !issue.rdy_j &&
    tag_hit(cdb_valid, cdb_tag, issue.qj);
  assign byp_k = !issue.rdy_k &&
    tag_hit(cdb_valid, cdb_tag, issue.qk);

  assign hit_j = busy && !rdy_j &&
    tag_hit(cdb_valid, cdb_tag, qj);
  assign hit_k = busy && !rdy_k &&
    tag_hit(cdb_valid, cdb_tag, qk);

  assign ready = busy && rdy_j && rdy_k;

  // Slot state: clear, issue write, or dispatch/wakeup.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      rdy_j <= 1'b0;
      rdy_k <= 1'b0;
      qj    <= '0;
      qk    <= '0;
      op    <= '0;
    end else if (we) begin
      busy    <= 1'b1;
      op.func <= issue.func;
      op.rd   <= issue.rd;
      op.rob  <= issue.rob;
      op.vj   <= byp_j ? cdb_data : issue.vj;
      op.vk   <= byp_k ? cdb_data : issue.vk;
      rdy_j   <= issue.rdy_j | byp_j;
      rdy_k   <= issue.rdy_k | byp_k;
      qj      <= issue.qj;
      qk      <= issue.qk;
    end else begin
      if (deq) begin
        busy <= 1'b0;
      end
      if (hit_j) begin
        op.vj <= cdb_data;
        rdy_j <= 1'b1;
      end
      if (hit_k) begin
        op.vk <= cdb_data;
        rdy_k <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station.sv
// Reservation station: DEPTH slots, free/ready
// priority encoders and dispatch output registers.
module res_station
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk1,
  input  logic rst,
  input  logic flush,
  res_station_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] we;
  logic [DEPTH-1:0] deq;
  op_t              ent_op [DEPTH];

  logic             clr;
  logic             take;
  logic             disp;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  issue_t           iss;
  op_t              out_q;
  logic             exec_q;

  assign clr  = rst | flush;
  assign take = bus.issue_valid && bus.issue_ready;
  assign disp = bus.exec_ready && (|rdy);

  assign bus.issue_ready = !(&busy);

  // Pack the issue fields for the slots.
  always_comb begin
    iss       = '0;
    iss.func  = bus.issue_func;
    iss.rd    = bus.issue_rd;
    iss.rob   = bus.issue_rob;
    iss.vj    = bus.issue_vj;
    iss.vk    = bus.issue_vk;
    iss.rdy_j = bus.issue_rdy_j;
    iss.rdy_k = bus.issue_rdy_k;
    iss.qj    = bus.issue_qj;
    iss.qk    = bus.issue_qk;
  end

  // Lowest free slot and lowest ready slot.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (rdy[i])   sel_idx  = IDX_W'(i);
    end
  end

  // One-hot issue write and dispatch dequeue.
  always_comb begin
    we  = '0;
    deq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i]  = take && (free_idx == IDX_W'(i));
      deq[i] = disp && (sel_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry u_ent (
      .clk       (clk1),
      .rst       (clr),
      .we        (we[g]),
      .issue     (iss),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_data  (bus.cdb_data),
      .deq       (deq[g]),
      .busy      (busy[g]),
      .ready     (rdy[g]),
      .op        (ent_op[g])
    );
  end

  // Dispatch registers; data holds when idle.
  always_ff @(posedge clk1) begin
    if (clr) begin
      exec_q <= 1'b0;
      out_q  <= '0;
    end else if (disp) begin
      exec_q <= 1'b1;
      out_q  <= ent_op[sel_idx];
    end else begin
      exec_q <= 1'b0;
    end
  end

  assign bus.exec_b   = exec_q;
  assign bus.func     = out_q.func;
  assign bus.rd       = out_q.rd;
  assign bus.rob_ind  = out_q.rob;
  assign bus.rs1_data = out_q.vj;
  assign bus.rs2_data = out_q.vk;

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: vector table
// plus hand sequences for full/hold and flush.
module tb_res_station;
  import tomasulo_pkg::*;

  typedef struct {
    logic       iv;
    logic [3:0] f;
    logic [3:0] rd;
    logic [2:0] rob;
    logic [7:0] vj;
    logic [7:0] vk;
    logic       rj;
    logic       rk;
    logic [2:0] qj;
    logic [2:0] qk;
    logic       cv;
    logic [2:0] ct;
    logic [7:0] cd;
    logic       er;
    logic       eb;
    logic [3:0] ef;
    logic [3:0] erd;
    logic [2:0] erob;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       eir;
  } vec_t;

  logic clk1 = 1'b0;
  logic rst;
  logic flush;

  res_station_if bus ();

  res_station #(.DEPTH(4)) dut (
    .clk1  (clk1),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  int   passed = 0;
  int   total  = 0;
  bit   [7:0] live = '0;
  vec_t vt[$];

  function automatic vec_t v_idle();
    vec_t v;
    v = '{default: '0};
    v.er  = 1'b1;
    v.eir = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_iss(
    input logic [3:0] f, rd,
    input logic [2:0] rob,
    input logic [7:0] vj, vk,
    input logic rj, rk,
    input logic [2:0] qj, qk
  );
    vec_t v;
    v = v_idle();
    v.iv = 1'b1;
    v.f = f;   v.rd = rd;  v.rob = rob;
    v.vj = vj; v.vk = vk;
    v.rj = rj; v.rk = rk;
    v.qj = qj; v.qk = qk;
    return v;
  endfunction

  function automatic vec_t v_cdb(
    input vec_t v,
    input logic [2:0] t,
    input logic [7:0] d
  );
    vec_t r;
    r = v;
    r.cv = 1'b1; r.ct = t; r.cd = d;
    return r;
  endfunction

  function automatic vec_t v_exp(
    input vec_t v,
    input logic [3:0] f, rd,
    input logic [2:0] rob,
    input logic [7:0] a, b
  );
    vec_t r;
    r = v;
    r.eb = 1'b1;
    r.ef = f; r.erd = rd; r.erob = rob;
    r.e1 = a; r.e2 = b;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_func  = v.f;
    bus.issue_rd    = v.rd;
    bus.issue_rob   = v.rob;
    bus.issue_vj    = v.vj;
    bus.issue_vk    = v.vk;
    bus.issue_rdy_j = v.rj;
    bus.issue_rdy_k = v.rk;
    bus.issue_qj    = v.qj;
    bus.issue_qk    = v.qk;
    bus.cdb_valid   = v.cv;
    bus.cdb_tag     = v.ct;
    bus.cdb_data    = v.cd;
    bus.exec_ready  = v.er;
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h want %h",
                  nm, act, exp);
  endtask

  task automatic mark(input logic [2:0] t);
    assert (!live[t])
      else $error("duplicate busy rob tag %0d", t);
    live[t] = 1'b1;
  endtask

  task automatic chk_op(
    input string nm,
    input logic [3:0] f, rd,
    input logic [2:0] rob,
    input logic [7:0] a, b
  );
    chk({nm, "_eb"}, 32'(bus.exec_b), 32'd1);
    chk({nm, "_op"},
        32'({bus.func, bus.rd, bus.rob_ind,
             bus.rs1_data, bus.rs2_data}),
        32'({f, rd, rob, a, b}));
    live[rob] = 1'b0;
  endtask

  task automatic iss_hold(
    input logic [2:0] rob,
    input logic [7:0] a, b,
    input logic er
  );
    vec_t v;
    v = v_iss(4'h0, 4'(rob), rob, a, b,
              1'b1, 1'b1, 3'd0, 3'd0);
    v.er = er;
    drive(v);
  endtask

  initial begin
    vec_t v;
    rst   = 1'b1;
    flush = 1'b0;
    drive(v_idle());
    step();
    step();
    chk("rst_eb", 32'(bus.exec_b), 32'd0);
    chk("rst_ir", 32'(bus.issue_ready), 32'd1);
    chk("rst_op",
        32'({bus.func, bus.rd, bus.rob_ind,
             bus.rs1_data, bus.rs2_data}),
        32'd0);
    rst = 1'b0;

    // ADD both ready
    vt.push_back(v_iss(4'h0, 4'h4, 3'd2, 8'h05,
      8'h03, 1, 1, 3'd0, 3'd0));
    vt.push_back(v_exp(v_idle(), 4'h0, 4'h4,
      3'd2, 8'h05, 8'h03));
    // MUL waiting on tag 3
    vt.push_back(v_iss(4'h2, 4'h1, 3'd4, 8'h00,
      8'h07, 0, 1, 3'd3, 3'd0));
    vt.push_back(v_idle());
    vt.push_back(v_cdb(v_idle(), 3'd3, 8'h09));
    vt.push_back(v_exp(v_idle(), 4'h2, 4'h1,
      3'd4, 8'h09, 8'h07));
    // issue-time bypass from tag 5
    vt.push_back(v_cdb(v_iss(4'h1, 4'h2, 3'd6,
      8'h00, 8'h01, 0, 1, 3'd5, 3'd0),
      3'd5, 8'hAA));
    vt.push_back(v_exp(v_idle(), 4'h1, 4'h2,
      3'd6, 8'hAA, 8'h01));
    // tags 1 and 6 pending, only 6 wakes
    vt.push_back(v_iss(4'h0, 4'h3, 3'd0, 8'h00,
      8'h10, 0, 1, 3'd1, 3'd0));
    vt.push_back(v_iss(4'h3, 4'h5, 3'd7, 8'h00,
      8'h20, 0, 1, 3'd6, 3'd0));
    vt.push_back(v_cdb(v_idle(), 3'd6, 8'h66));
    vt.push_back(v_exp(v_idle(), 4'h3, 4'h5,
      3'd7, 8'h66, 8'h20));
    vt.push_back(v_idle());
    vt.push_back(v_cdb(v_idle(), 3'd1, 8'h11));
    vt.push_back(v_exp(v_idle(), 4'h0, 4'h3,
      3'd0, 8'h11, 8'h10));
    // store passes rd through untouched
    vt.push_back(v_iss(4'h5, 4'h9, 3'd3, 8'h12,
      8'h34, 1, 1, 3'd0, 3'd0));
    vt.push_back(v_exp(v_idle(), 4'h5, 4'h9,
      3'd3, 8'h12, 8'h34));
    // j and k on the same broadcast
    vt.push_back(v_iss(4'h4, 4'h6, 3'd1, 8'h00,
      8'h00, 0, 0, 3'd2, 3'd2));
    vt.push_back(v_cdb(v_idle(), 3'd2, 8'h5A));
    vt.push_back(v_exp(v_idle(), 4'h4, 4'h6,
      3'd1, 8'h5A, 8'h5A));
    vt.push_back(v_idle());

    foreach (vt[i]) begin
      if (vt[i].iv) mark(vt[i].rob);
      drive(vt[i]);
      step();
      chk($sformatf("v%0d_eb", i),
          32'(bus.exec_b), 32'(vt[i].eb));
      chk($sformatf("v%0d_ir", i),
          32'(bus.issue_ready), 32'(vt[i].eir));
      if (vt[i].eb) begin
        chk_op($sformatf("v%0d", i), vt[i].ef,
               vt[i].erd, vt[i].erob,
               vt[i].e1, vt[i].e2);
      end
    end

    // Fill with exec stalled, hold a fifth issue.
    for (int i = 0; i < 4; i++) begin
      mark(3'(i));
      iss_hold(3'(i), 8'(i), 8'(i + 1), 1'b0);
      step();
      chk($sformatf("fill%0d_ir", i),
          32'(bus.issue_ready), 32'(i < 3));
      chk($sformatf("fill%0d_eb", i),
          32'(bus.exec_b), 32'd0);
    end
    iss_hold(3'd4, 8'h44, 8'h45, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("hold%0d_ir", i),
          32'(bus.issue_ready), 32'd0);
      chk($sformatf("hold%0d_eb", i),
          32'(bus.exec_b), 32'd0);
    end
    iss_hold(3'd4, 8'h44, 8'h45, 1'b1);
    step();
    chk_op("full_d0", 4'h0, 4'h0, 3'd0,
           8'h00, 8'h01);
    chk("full_ir", 32'(bus.issue_ready), 32'd1);
    mark(3'd4);
    step();
    chk_op("full_d1", 4'h0, 4'h1, 3'd1,
           8'h01, 8'h02);
    drive(v_idle());
    step();
    chk_op("full_d4", 4'h0, 4'h4, 3'd4,
           8'h44, 8'h45);
    step();
    chk_op("full_d2", 4'h0, 4'h2, 3'd2,
           8'h02, 8'h03);
    step();
    chk_op("full_d3", 4'h0, 4'h3, 3'd3,
           8'h03, 8'h04);
    step();
    chk("full_end_eb", 32'(bus.exec_b), 32'd0);

    // Flush with one ready entry and two pending.
    v = v_iss(4'h0, 4'h1, 3'd0, 8'hC0, 8'hC1,
              1, 1, 3'd0, 3'd0);
    v.er = 1'b0;
    mark(3'd0); drive(v); step();
    v = v_iss(4'h1, 4'h2, 3'd1, 8'h00, 8'hC2,
              0, 1, 3'd7, 3'd0);
    v.er = 1'b0;
    mark(3'd1); drive(v); step();
    v = v_iss(4'h2, 4'h3, 3'd2, 8'hC3, 8'h00,
              1, 0, 3'd0, 3'd7);
    v.er = 1'b0;
    mark(3'd2); drive(v); step();
    chk("pre_fl_eb", 32'(bus.exec_b), 32'd0);
    drive(v_idle());
    flush = 1'b1;
    step();
    flush = 1'b0;
    live = '0;
    chk("fl_eb", 32'(bus.exec_b), 32'd0);
    chk("fl_ir", 32'(bus.issue_ready), 32'd1);
    drive(v_cdb(v_idle(), 3'd7, 8'h77));
    step();
    chk("fl_cdb_eb", 32'(bus.exec_b), 32'd0);
    drive(v_idle());
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("fl_idle%0d_eb", i),
          32'(bus.exec_b), 32'd0);
    end
    mark(3'd5);
    drive(v_iss(4'h3, 4'h7, 3'd5, 8'h51, 8'h52,
                1, 1, 3'd0, 3'd0));
    step();
    drive(v_idle());
    step();
    chk_op("post_fl", 4'h3, 4'h7, 3'd5,
           8'h51, 8'h52);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
